// File: rtl/shift_pkg.sv
// Shared constants, op encodings, controller states and helpers for the shift unit.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROTL = 3'b011;
    localparam logic [2:0] OP_ROTR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROTR);
    endfunction

endpackage

// File: rtl/shift_unit_ctrl_if.sv
// Request/response handshake bundle between a requester and the shift controller.
interface shift_unit_ctrl_if;
    import shift_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [DATA_W-1:0]   req_data;
    logic [SHAMT_W-1:0]  req_amt;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;

    modport master (
        output req_valid, req_op, req_data, req_amt, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, req_amt, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/shift_core_left.sv
// Combinational logarithmic left shifter: stage k shifts by 2^k when amt[k] is set, zero fill.
module shift_core_left
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] amt,
    output logic [DATA_W-1:0]  shifted
);

    logic [DATA_W-1:0] stage [SHAMT_W+1];

    assign stage[0] = data;

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            assign stage[gi+1] = amt[gi] ? (stage[gi] << (1 << gi)) : stage[gi];
        end
    endgenerate

    assign shifted = stage[SHAMT_W];

endmodule

// File: rtl/shift_unit_ctrl.sv
// Shift/rotate sequencer: right shifts mirror through one left-shift core, rotates take two passes.
module shift_unit_ctrl
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    shift_unit_ctrl_if.slave   bus,
    output logic               busy
);

    state_t              state_reg, state_next;
    logic [2:0]          op_reg, op_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [SHAMT_W-1:0]  amt_reg, amt_next;
    logic [DATA_W-1:0]   partial_reg, partial_next;
    logic [DATA_W-1:0]   result_reg, result_next;
    logic                err_reg, err_next;

    logic [DATA_W-1:0]   sh_in;
    logic [SHAMT_W-1:0]  sh_amt;
    logic [DATA_W-1:0]   sh_out;
    logic                sign;

    assign sign = data_reg[DATA_W-1];

    shift_core_left u_core (
        .data    (sh_in),
        .amt     (sh_amt),
        .shifted (sh_out)
    );

    // Core input mux, kept apart from post-processing so the core sits between two comb blocks.
    always_comb begin
        sh_in  = data_reg;
        sh_amt = amt_reg;
        if (state_reg == EXEC1) begin
            case (op_reg)
                OP_SRL, OP_ROTR: sh_in = rev(data_reg);
                OP_SRA:          sh_in = rev(sign ? ~data_reg : data_reg);
                default:         sh_in = data_reg;
            endcase
        end else if (state_reg == EXEC2) begin
            sh_amt = '0 - amt_reg;
            sh_in  = (op_reg == OP_ROTL) ? rev(data_reg) : data_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        data_next    = data_reg;
        amt_next     = amt_reg;
        partial_next = partial_reg;
        result_next  = result_reg;
        err_next     = err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    op_next      = bus.req_op;
                    data_next    = bus.req_data;
                    amt_next     = bus.req_amt;
                    partial_next = '0;
                    if (op_legal(bus.req_op)) begin
                        err_next   = 1'b0;
                        state_next = EXEC1;
                    end else begin
                        result_next = '0;
                        err_next    = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            EXEC1: begin
                state_next = DONE;
                case (op_reg)
                    OP_SLL:  result_next = sh_out;
                    OP_SRL:  result_next = rev(sh_out);
                    OP_SRA:  result_next = sign ? ~rev(sh_out) : rev(sh_out);
                    OP_ROTL: partial_next = sh_out;
                    default: partial_next = rev(sh_out);
                endcase
                if (op_reg == OP_ROTL || op_reg == OP_ROTR) begin
                    if (amt_reg == '0) begin
                        result_next = data_reg;
                    end else begin
                        state_next = EXEC2;
                    end
                end
            end
            EXEC2: begin
                result_next = (op_reg == OP_ROTL) ? (partial_reg | rev(sh_out))
                                                  : (partial_reg | sh_out);
                state_next  = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            data_reg    <= '0;
            amt_reg     <= '0;
            partial_reg <= '0;
            result_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            data_reg    <= data_next;
            amt_reg     <= amt_next;
            partial_reg <= partial_next;
            result_reg  <= result_next;
            err_reg     <= err_next;
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = (state_reg == DONE);
    assign bus.resp_data  = result_reg;
    assign bus.resp_err   = err_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Scoreboard bench for shift_unit_ctrl: directed vectors, decoupled response monitor.
module tb_shift_unit_ctrl;
    import shift_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   seen = 1'b0;
    exp_t sb[$];

    shift_unit_ctrl_if bus ();

    shift_unit_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && bus.req_valid && bus.req_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one scoreboard pop per presented response.
    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp actual=%h required=none", bus.resp_data);
                end else begin
                    e = sb.pop_front();
                    chk("resp_data", bus.resp_data, e.data);
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    $display("resp data=%h err=%0d lat=%0d", bus.resp_data, bus.resp_err, cyc - e.acc + 1);
                end
            end
            if (bus.resp_ready) seen = 1'b0;
        end else begin
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] data, input logic [4:0] amt,
                         input logic [31:0] exp_data, input logic exp_err, input int lat,
                         input bit push, input bit wait_done);
        exp_t e;
        @(negedge clk);
        bus.req_op    = op;
        bus.req_data  = data;
        bus.req_amt   = amt;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (push) begin
            e.data = exp_data;
            e.err  = exp_err;
            e.lat  = lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
        $display("req op=%0d data=%h amt=%0d", op, data, amt);
        if (wait_done) begin
            for (int i = 0; i < 50 && (busy || sb.size() != 0); i++) @(negedge clk);
            if (busy) chk("done_timeout", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int acc0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_data   = '0;
        bus.req_amt    = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        issue(OP_SLL,  32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 2, 1, 1);
        issue(OP_SRL,  32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 2, 1, 1);
        issue(OP_SRA,  32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 2, 1, 1);
        issue(OP_SRA,  32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1'b0, 2, 1, 1);
        issue(OP_ROTL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 3, 1, 1);
        issue(OP_ROTR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 3, 1, 1);
        issue(OP_ROTL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 2, 1, 1);
        issue(OP_ROTR, 32'h1234_5678, 5'd4,  32'h8123_4567, 1'b0, 3, 1, 1);
        issue(OP_ROTL, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 3, 1, 1);
        issue(OP_SLL,  32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0, 2, 1, 1);
        issue(OP_SRL,  32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 2, 1, 1);
        issue(OP_SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 2, 1, 1);
        issue(3'b111,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 1'b1, 1, 1, 1);
        issue(3'b101,  32'h1234_5678, 5'd0,  32'h0000_0000, 1'b1, 1, 1, 1);
        issue(OP_ROTR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 2, 1, 1);

        // Backpressure: response held while a second request waits.
        bus.resp_ready = 1'b0;
        issue(OP_SLL, 32'h0000_000F, 5'd4, 32'h0000_00F0, 1'b0, 2, 1, 0);
        for (int i = 0; i < 20 && !bus.resp_valid; i++) @(negedge clk);
        bus.req_op    = OP_SLL;
        bus.req_data  = 32'h0000_0005;
        bus.req_amt   = 5'd1;
        bus.req_valid = 1'b1;
        acc0 = n_acc;
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_data", bus.resp_data, 32'h0000_00F0);
            chk("bp_resp_err", 32'(bus.resp_err), 32'd0);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        chk("bp_no_accept", 32'(n_acc - acc0), 32'd0);
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);

        // Reset during EXEC2 of a rotate: request is dropped silently.
        issue(OP_ROTL, 32'h8000_0001, 5'd1, 32'h0, 1'b0, 3, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst2_resp_data", bus.resp_data, 32'h0);
        chk("rst2_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst2_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst2_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);

        issue(OP_SLL, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 2, 1, 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_unit_ctrl.md
Name: shift_unit_ctrl

Overview:
- Sequencing controller around one shared 32-bit logarithmic left-shift core.
- Executes SLL, SRL, SRA, ROTL and ROTR with a valid/ready request/response handshake.
- Right shifts use bit reversal around the left shifter. Rotates take two passes through the same core.
- Sits beside the ALU and serves shift and rotate instructions.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; always log2(DATA_W).

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request; high only in IDLE
- req_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROTL, 100 ROTR, 101..111 illegal
- req_data  input  32  operand
- req_amt  input  5  shift amount 0..31
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts the result
- resp_data  output  32  result
- resp_err  output  1  illegal op flag, qualified by resp_valid
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. reset=1 at a clk edge forces:
  - state IDLE
  - resp_valid 0, resp_data 0, resp_err 0
  - all operand and partial registers cleared
- Reset overrides any handshake in the same cycle. No response is ever produced for a request in flight at reset.
- Accept: req_valid && req_ready at an edge latches op, data and amt.
- States and transitions:
  - IDLE: goes to EXEC1 on accept of a legal op; goes to DONE on accept of an illegal op.
  - EXEC1: core input sh_in and amount sh_amt come from the latched registers. The core output is post-processed and captured.
    - SLL: sh_in = x, sh_amt = n, result = core output.
    - SRL: sh_in = rev(x), sh_amt = n, result = rev(core output).
    - SRA: s = x[31]. sh_in = rev(s ? ~x : x), sh_amt = n, result = s ? ~rev(out) : rev(out).
    - ROTL: sh_in = x, sh_amt = n, partial = out.
    - ROTR: sh_in = rev(x), sh_amt = n, partial = rev(out).
    - SLL/SRL/SRA, and ROTL/ROTR with n = 0, go to DONE. For rotates with n = 0 the result is x unchanged.
    - Any other rotate goes to EXEC2.
  - EXEC2 (rotates, n != 0):
    - ROTL: sh_in = rev(x), sh_amt = 32-n (fits in 5 bits since n >= 1), result = partial | rev(out).
    - ROTR: sh_in = x, sh_amt = 32-n, result = partial | out.
    - Then go to DONE.
  - DONE: resp_valid = 1. resp_data and resp_err stay stable until resp_valid && resp_ready, then go to IDLE.
- Illegal op: resp_data = 0, resp_err = 1.
- Latency from accept edge to resp_valid high:
  - illegal op: 1 cycle
  - SLL/SRL/SRA and zero-amount rotates: 2 cycles
  - rotates with n != 0: 3 cycles
- One operation in flight at a time. req_ready is 0 in EXEC1, EXEC2 and DONE, including the cycle resp is consumed. A new accept is possible the cycle after DONE exits.
- req_ready = (state == IDLE), decoded from state only. It is never combinationally dependent on req_valid.
- Amount arithmetic is modulo 32. All shifts fill with zero except SRA, which fills with the sign bit.
- Upper bits of resp_data never hold stale data: the result register is fully written on every capture.

Decomposition:
- Package shift_pkg holds:
  - DATA_W and SHAMT_W constants
  - op encoding constants (OP_SLL..OP_ROTR)
  - state enumeration (IDLE, EXEC1, EXEC2, DONE)
  - bit-reverse function
- Sub-module shift_core_left: purely combinational 32-bit left shifter.
  - 5 stages of 2:1 muxes, stage k shifting by 2^k, selected by amount bit k, zero fill.
  - Ports: data in, amt in, data out.
  - Instantiated exactly once. The controller owns its input mux and the output post-processing.

Test Plan:
- SLL, req_data 0x0000_0001, amt 31 -> resp_data 0x8000_0000, resp_err 0, resp_valid exactly 2 cycles after accept.
- SRL and SRA, req_data 0x8000_0000, amt 4 -> SRL 0x0800_0000, SRA 0xF800_0000. Also SRA 0x7FFF_FFF0 amt 4 -> 0x07FF_FFFF.
- Rotates:
  - ROTL 0x8000_0001 amt 1 -> 0x0000_0003, 3 cycles after accept.
  - ROTR 0x0000_0001 amt 1 -> 0x8000_0000.
  - ROTL 0xDEAD_BEEF amt 0 -> 0xDEAD_BEEF, 2 cycles after accept.
- Backpressure: hold resp_ready = 0 for 5 cycles in DONE while req_valid = 1 -> resp_valid/resp_data/resp_err stable, req_ready = 0, busy = 1, no second accept. Release -> IDLE next cycle, req_ready = 1.
- Illegal op 3'b111 with data 0xFFFF_FFFF -> resp_err 1, resp_data 0x0000_0000, 1 cycle after accept.
- Reset asserted for one cycle while in EXEC2 of a ROTL -> next cycle state IDLE, resp_valid 0, resp_data 0, req_ready 1; no response appears afterwards.
